// File: rtl/fact_ctrl.sv
// Sequencing stage for the factorial unit: runs the count-down multiply loop against
// an external combinational multiplier and presents n!, done and err over a 4-phase go/done handshake.
module fact_ctrl #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [N_W-1:0]    n,
  input  logic [DATA_W-1:0] mul_prod,
  output logic [N_W-1:0]    mul_count,
  output logic [DATA_W-1:0] mul_reg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result
);

  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);
  localparam logic [N_W-1:0] ONE_N   = N_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [N_W-1:0]      cnt;
  logic [DATA_W-1:0]   prod;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (go) begin
          if (n > MAX_N_V || n == '0) state_next = DONE;
          else                        state_next = MULT;
        end
      end
      MULT: begin
        // cnt==0 cannot occur in MULT; treating it as the last step keeps the loop bounded.
        if (cnt <= ONE_N) state_next = DONE;
      end
      DONE: begin
        if (!go) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so go and n never reach them combinationally.
  always_comb begin
    busy = (state == MULT);
    done = (state == DONE);
  end

  // Datapath: operand capture, running product, count-down and result/err registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      prod   <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            err <= 1'b0;
            if (n > MAX_N_V) begin
              err    <= 1'b1;
              result <= '0;
            end else if (n == '0) begin
              result <= DATA_W'(1);
            end else begin
              cnt  <= n;
              prod <= DATA_W'(1);
            end
          end
        end
        MULT: begin
          prod <= mul_prod;
          if (cnt > ONE_N) cnt    <= cnt - ONE_N;
          else             result <= mul_prod;
        end
        default: ;
      endcase
    end
  end

  assign mul_count = cnt;
  assign mul_reg   = prod;

endmodule

// File: tb/tb_fact_ctrl.sv
// Scoreboard bench for fact_ctrl: a combinational multiplier model closes the loop,
// the driver queues expected completions and a monitor checks each done pulse.
module tb_fact_ctrl;

  localparam int DATA_W = 32;
  localparam int N_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [N_W-1:0]    n;
  logic [DATA_W-1:0] mul_prod;
  logic [N_W-1:0]    mul_count;
  logic [DATA_W-1:0] mul_reg;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;

  typedef struct {
    longint res;
    longint err;
    longint busy_len;
    longint done_len;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fact_ctrl #(.DATA_W(DATA_W), .N_W(N_W), .MAX_N(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .n         (n),
    .mul_prod  (mul_prod),
    .mul_count (mul_count),
    .mul_reg   (mul_reg),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  assign mul_prod = {{(DATA_W-N_W){1'b0}}, mul_count} * mul_reg;

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rising done and checks how long done stays high.
  initial begin
    exp_t   cur;
    logic   have = 1'b0;
    logic   done_prev = 1'b0;
    longint busy_cnt = 0;
    longint done_cnt = 0;
    forever begin
      @(negedge clk);
      if (busy)       busy_cnt++;
      else if (!done) busy_cnt = 0;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
          have = 1'b0;
        end else begin
          cur = sb.pop_front();
          check("result", result, cur.res);
          check("err", err, cur.err);
          check("busy_len", busy_cnt, cur.busy_len);
          have = 1'b1;
        end
        busy_cnt = 0;
        done_cnt = 1;
      end else if (done) begin
        done_cnt++;
      end else if (done_prev && have) begin
        check("done_len", done_cnt, cur.done_len);
        have = 1'b0;
      end
      done_prev = done;
    end
  end

  task automatic push(input longint res, input longint e, input longint bl, input longint dl);
    exp_t x;
    x.res = res; x.err = e; x.busy_len = bl; x.done_len = dl;
    sb.push_back(x);
  endtask

  // Full handshake: go held until done seen plus two cycles, then released.
  task automatic run_cmd(input int n_val, input longint exp_res, input longint exp_err);
    int   lat;
    logic seen;
    int   exp_lat;
    exp_lat = (exp_err != 0 || n_val == 0) ? 1 : n_val + 1;
    push(exp_res, exp_err, (exp_lat == 1) ? 0 : n_val, 3);
    n    = N_W'(n_val);
    go   = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) n = ~N_W'(n_val);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("latency", lat, exp_lat);
    repeat (2) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("done_fall", done, 0);
    check("busy_idle", busy, 0);
    check("err_hold", err, exp_err);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst = 1'b1;
    go  = 1'b0;
    n   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);

    run_cmd(5, 120, 0);
    run_cmd(12, 479001600, 0);
    run_cmd(13, 0, 1);
    run_cmd(0, 1, 0);
    run_cmd(1, 1, 0);

    // Reset in the 4th MULT cycle of n=9 discards the computation.
    n  = 4'd9;
    go = 1'b1;
    repeat (4) @(negedge clk);
    check("mult_busy", busy, 1);
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_count", mul_count, 0);
    check("mid_rst_reg", mul_reg, 0);
    run_cmd(3, 6, 0);

    // go dropped in the 2nd MULT cycle: done lasts exactly one cycle.
    push(24, 0, 4, 1);
    n  = 4'd4;
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    go = 1'b0;
    lat  = 2;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("early_drop_seen", seen, 1);
    check("early_drop_latency", lat, 5);
    @(negedge clk);
    check("early_drop_done", done, 0);
    check("early_drop_busy", busy, 0);
    check("early_drop_result", result, 24);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
